// File: rtl/pwr_cntr_mem_pkg.sv
// Shared types and helpers for the power-event counter memory.
`default_nettype none

package pwr_cntr_mem_pkg;

   typedef enum logic [1:0] {
      PWR_IDLE  = 2'd0,
      PWR_ACCUM = 2'd1,
      PWR_DUMP  = 2'd2
   } pwr_state_e;

   // Index width that stays legal for a single-channel build.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pwr_sat_acc.sv
// Saturating unsigned accumulator with synchronous clear and sticky overflow flag.
`default_nettype none

module pwr_sat_acc #(
   parameter int W     = 16,
   parameter int INC_W = 4
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             clr,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [W-1:0]     val,
   output logic             sat
);

   // One extra bit over the wider operand so the carry out is never lost.
   localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
   localparam logic [SW-1:0] MAX_VAL = {{(SW-W){1'b0}}, {W{1'b1}}};

   logic [SW-1:0] sum;
   logic [W-1:0]  val_q, val_d;
   logic          sat_q, sat_d;

   always_comb begin
      sum   = SW'(val_q) + SW'(inc);
      val_d = val_q;
      sat_d = sat_q;
      if (clr) begin
         val_d = '0;
         sat_d = 1'b0;
      end else if (en) begin
         if (sum > MAX_VAL) begin
            val_d = '1;
            sat_d = 1'b1;
         end else begin
            val_d = sum[W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         val_q <= '0;
         sat_q <= 1'b0;
      end else begin
         val_q <= val_d;
         sat_q <= sat_d;
      end
   end

   assign val = val_q;
   assign sat = sat_q;

endmodule

`default_nettype wire

// File: rtl/pwr_cntr_mem.sv
// Per-channel weighted rising-edge counters with running total and valid/ready readout.
`default_nettype none

module pwr_cntr_mem
   import pwr_cntr_mem_pkg::*;
#(
   parameter int NUM_CNTR = 8,
   parameter int CNT_W    = 16,
   parameter int WEIGHT_W = 4,
   parameter int TOT_W    = 20
) (
   input  logic                         clk,
   input  logic                         reset_L,
   input  logic [NUM_CNTR-1:0]          sig_in,
   input  logic [NUM_CNTR*WEIGHT_W-1:0] weight_in,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         dump,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [idx_w(NUM_CNTR)-1:0]   rd_idx,
   output logic [CNT_W-1:0]             rd_data,
   output logic                         rd_last,
   output logic [TOT_W-1:0]             pwr_total,
   output logic [NUM_CNTR-1:0]          sat_flag,
   output logic                         busy
);

   localparam int IDX_W = idx_w(NUM_CNTR);
   // Wide enough for every channel rising with its maximum weight in one cycle.
   localparam int SUM_W = WEIGHT_W + idx_w(NUM_CNTR + 1);

   pwr_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_CNTR-1:0] sig_q;
   logic [NUM_CNTR-1:0] rise;
   logic [SUM_W-1:0]    wsum;
   logic                clr;
   logic                acc_en;
   logic                idx_last;
   logic                tot_sat_unused;
   logic [CNT_W-1:0]    cnt [NUM_CNTR];

   assign rise     = sig_in & ~sig_q;
   assign idx_last = (idx_q == IDX_W'(NUM_CNTR - 1));

   always_comb begin
      wsum = '0;
      for (int i = 0; i < NUM_CNTR; i++) begin
         if (rise[i]) begin
            wsum = wsum + SUM_W'(weight_in[i*WEIGHT_W +: WEIGHT_W]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr     = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         PWR_IDLE: begin
            if (start) begin
               state_d = PWR_ACCUM;
               clr     = 1'b1;
            end else if (dump) begin
               state_d = PWR_DUMP;
               idx_d   = '0;
            end
         end
         PWR_ACCUM: begin
            if (start) begin
               clr = 1'b1;
            end else begin
               acc_en = 1'b1;
               if (stop) begin
                  state_d = PWR_DUMP;
                  idx_d   = '0;
               end
            end
         end
         PWR_DUMP: begin
            if (rd_ready) begin
               if (idx_last) begin
                  state_d = PWR_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = PWR_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= PWR_IDLE;
         idx_q   <= '0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sig_q   <= sig_in;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CNTR; gi++) begin : g_cntr
         pwr_sat_acc #(
            .W     (CNT_W),
            .INC_W (WEIGHT_W)
         ) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .clr     (clr),
            .en      (acc_en & rise[gi]),
            .inc     (weight_in[gi*WEIGHT_W +: WEIGHT_W]),
            .val     (cnt[gi]),
            .sat     (sat_flag[gi])
         );
      end
   endgenerate

   pwr_sat_acc #(
      .W     (TOT_W),
      .INC_W (SUM_W)
   ) u_total (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (clr),
      .en      (acc_en),
      .inc     (wsum),
      .val     (pwr_total),
      .sat     (tot_sat_unused)
   );

   assign busy     = (state_q != PWR_IDLE);
   assign rd_valid = (state_q == PWR_DUMP);
   assign rd_idx   = idx_q;
   assign rd_last  = rd_valid & idx_last;
   assign rd_data  = rd_valid ? cnt[idx_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_pwr_cntr_mem.sv
// Self-checking bench: default-size instance plus a narrow instance for saturation.
`default_nettype none

module tb_pwr_cntr_mem;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_L;
   logic [7:0]  sig_in;
   logic [31:0] weight_a, weight_b;
   logic        start_a, stop_a, dump_a, start_b, stop_b, dump_b;
   logic        rd_ready;

   logic        a_valid, a_last, a_busy;
   logic [2:0]  a_idx;
   logic [15:0] a_data;
   logic [19:0] a_total;
   logic [7:0]  a_sat;

   logic        b_valid, b_last, b_busy;
   logic [2:0]  b_idx;
   logic [3:0]  b_data;
   logic [5:0]  b_total;
   logic [7:0]  b_sat;

   pwr_cntr_mem #(.NUM_CNTR(8), .CNT_W(16), .WEIGHT_W(4), .TOT_W(20)) u_dut_a (
      .clk(clk), .reset_L(reset_L), .sig_in(sig_in), .weight_in(weight_a),
      .start(start_a), .stop(stop_a), .dump(dump_a),
      .rd_valid(a_valid), .rd_ready(rd_ready), .rd_idx(a_idx), .rd_data(a_data),
      .rd_last(a_last), .pwr_total(a_total), .sat_flag(a_sat), .busy(a_busy)
   );

   pwr_cntr_mem #(.NUM_CNTR(8), .CNT_W(4), .WEIGHT_W(4), .TOT_W(6)) u_dut_b (
      .clk(clk), .reset_L(reset_L), .sig_in(sig_in), .weight_in(weight_b),
      .start(start_b), .stop(stop_b), .dump(dump_b),
      .rd_valid(b_valid), .rd_ready(rd_ready), .rd_idx(b_idx), .rd_data(b_data),
      .rd_last(b_last), .pwr_total(b_total), .sat_flag(b_sat), .busy(b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]  idx;
      logic [15:0] data;
      logic        last;
   } ent_t;
   ent_t sb[$];

   typedef struct {
      int         ch;
      int         n;
      logic [3:0] w;
   } vec_t;

   logic [15:0] exp_cnt [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rise_ch(input int ch);
      sig_in     = 8'h00;
      sig_in[ch] = 1'b1;
      tick();
      sig_in = 8'h00;
      tick();
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) exp_cnt[i] = 16'd0;
   endtask

   task automatic push_all();
      ent_t e;
      for (int i = 0; i < 8; i++) begin
         e.idx  = 3'(i);
         e.data = exp_cnt[i];
         e.last = (i == 7);
         sb.push_back(e);
      end
   endtask

   // Drains the scoreboard from the selected DUT, optionally stalling at one index.
   task automatic collect(input bit sel, input int stall_idx, input int stall_n);
      int    budget  = 0;
      int    stalled = 0;
      logic        v, l;
      logic [2:0]  ix;
      logic [15:0] d;
      ent_t  e;
      while (sb.size() > 0 && budget < 60) begin
         budget++;
         v  = sel ? b_valid : a_valid;
         ix = sel ? b_idx : a_idx;
         d  = sel ? 16'(b_data) : a_data;
         l  = sel ? b_last : a_last;
         if (!v) begin
            chk("dump_valid", v, 1);
            sb.delete();
         end else if (int'(ix) == stall_idx && stalled < stall_n) begin
            rd_ready = 1'b0;
            chk("bp_idx", ix, sb[0].idx);
            chk("bp_data", d, sb[0].data);
            stalled++;
            tick();
         end else begin
            rd_ready = 1'b1;
            e = sb.pop_front();
            chk("rd_idx", ix, e.idx);
            chk("rd_data", d, e.data);
            chk("rd_last", l, e.last);
            tick();
         end
      end
      if (sb.size() > 0) begin
         chk("dump_timeout", 0, 1);
         sb.delete();
      end
      rd_ready = 1'b0;
      chk("dump_end_busy", sel ? b_busy : a_busy, 0);
      chk("dump_end_valid", sel ? b_valid : a_valid, 0);
   endtask

   vec_t tbl [4];

   initial begin
      tbl[0] = '{ch: 2, n: 5, w: 4'd3};
      tbl[1] = '{ch: 0, n: 1, w: 4'd15};
      tbl[2] = '{ch: 7, n: 4, w: 4'd9};
      tbl[3] = '{ch: 5, n: 0, w: 4'd6};

      reset_L  = 1'b0;
      sig_in   = 8'h00;
      weight_a = '0;
      weight_b = '0;
      {start_a, stop_a, dump_a, start_b, stop_b, dump_b} = '0;
      rd_ready = 1'b0;

      // Reset with random activity on the inputs
      repeat (4) begin
         sig_in = 8'($urandom);
         tick();
      end
      chk("rst_valid", a_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_total", a_total, 0);
      chk("rst_sat", a_sat, 0);
      chk("rst_idx", a_idx, 0);
      chk("rst_data", a_data, 0);
      chk("rst_last", a_last, 0);
      chk("rst_busy_b", b_busy, 0);
      reset_L = 1'b1;
      sig_in  = 8'h00;
      tick();
      tick();
      chk("post_rst_busy", a_busy, 0);

      // Table-driven single-channel accumulation runs
      for (int t = 0; t < 4; t++) begin
         clear_model();
         exp_cnt[tbl[t].ch] = 16'(tbl[t].n * int'(tbl[t].w));
         weight_a = {8{tbl[t].w}};
         start_a  = 1'b1;
         tick();
         start_a = 1'b0;
         chk("accum_busy", a_busy, 1);
         for (int k = 0; k < tbl[t].n; k++) rise_ch(tbl[t].ch);
         stop_a = 1'b1;
         tick();
         stop_a = 1'b0;
         chk("tbl_total", a_total, 32'(tbl[t].n * int'(tbl[t].w)));
         push_all();
         collect(1'b0, -1, 0);
      end

      // All channels rise on the stop edge; DUMP ignores rises and commands
      for (int i = 0; i < 8; i++) weight_a[i*4 +: 4] = 4'(i + 1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      sig_in  = 8'hFF;
      stop_a  = 1'b1;
      tick();
      sig_in = 8'h00;
      stop_a = 1'b0;
      chk("simul_total", a_total, 36);
      tick();
      sig_in  = 8'hFF;
      start_a = 1'b1;
      tick();
      sig_in  = 8'h00;
      start_a = 1'b0;
      tick();
      chk("dump_ignore_total", a_total, 36);
      chk("dump_ignore_idx", a_idx, 0);
      clear_model();
      for (int i = 0; i < 8; i++) exp_cnt[i] = 16'(i + 1);
      push_all();
      collect(1'b0, 3, 5);
      dump_a = 1'b1;
      tick();
      dump_a = 1'b0;
      push_all();
      collect(1'b0, -1, 0);

      // Narrow instance: counter and total saturation
      weight_b = {8{4'd7}};
      start_b  = 1'b1;
      tick();
      start_b = 1'b0;
      repeat (3) rise_ch(0);
      chk("sat_flag_ch0", b_sat, 8'h01);
      chk("sat_total21", b_total, 21);
      sig_in = 8'hFF;
      tick();
      sig_in = 8'h00;
      tick();
      chk("tot_saturate", b_total, 63);
      chk("sat_flag_only0", b_sat, 8'h01);
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;
      clear_model();
      exp_cnt[0] = 16'd15;
      for (int i = 1; i < 8; i++) exp_cnt[i] = 16'd7;
      push_all();
      collect(1'b1, -1, 0);
      chk("sat_sticky_idle", b_sat, 8'h01);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("sat_cleared", b_sat, 8'h00);
      chk("tot_cleared", b_total, 0);
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;
      clear_model();
      push_all();
      collect(1'b1, -1, 0);

      // start+stop in ACCUM restarts instead of dumping
      weight_a = {8{4'd3}};
      start_a  = 1'b1;
      tick();
      start_a = 1'b0;
      rise_ch(2);
      rise_ch(2);
      start_a = 1'b1;
      stop_a  = 1'b1;
      tick();
      start_a = 1'b0;
      stop_a  = 1'b0;
      chk("prio_busy", a_busy, 1);
      chk("prio_valid", a_valid, 0);
      chk("prio_total", a_total, 0);
      rise_ch(4);
      stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      clear_model();
      exp_cnt[4] = 16'd3;
      push_all();
      collect(1'b0, -1, 0);

      // start beats dump in IDLE; then reset in the middle of a dump
      start_a = 1'b1;
      dump_a  = 1'b1;
      tick();
      start_a = 1'b0;
      dump_a  = 1'b0;
      chk("start_wins_valid", a_valid, 0);
      chk("start_wins_busy", a_busy, 1);
      rise_ch(5);
      stop_a = 1'b1;
      tick();
      stop_a   = 1'b0;
      rd_ready = 1'b1;
      for (int k = 0; k < 10 && a_idx != 3'd5; k++) tick();
      rd_ready = 1'b0;
      chk("mid_dump_idx", a_idx, 5);
      chk("mid_dump_data", a_data, 3);
      reset_L = 1'b0;
      tick();
      reset_L = 1'b1;
      tick();
      chk("abort_busy", a_busy, 0);
      chk("abort_valid", a_valid, 0);
      chk("abort_total", a_total, 0);
      dump_a = 1'b1;
      tick();
      dump_a = 1'b0;
      clear_model();
      push_all();
      collect(1'b0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
